// File: rtl/mem_portb_reader.sv
// Streams a contiguous range of data memory out of the spare read port B over valid/ready.
// Optional running checksum of popped words: define PORTB_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; address_b holds the last issued address
// READ  | issuing one port-B read per cycle while FIFO credit allows
// DRAIN | all reads issued; waiting for returns and consumer to empty the FIFO
module mem_portb_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 24,
  parameter int LEN_W      = 18,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef PORTB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr, addr_hold;
  logic [LEN_W-1:0]  len_q, issued, pop_idx;
  logic [RD_LAT-1:0] tag_sr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count, inflight;
  logic              done_q;
  logic              accept, accept_zero, issue, push, pop, drain_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(tag_sr[i]);
    end
  end

  // Credit counts words already buffered plus reads still in the RAM pipe,
  // so a returning word always finds a free FIFO slot.
  assign issue       = (state == READ) &&
                       (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
  assign accept      = (state == IDLE) && start && !abort && (length != '0);
  assign accept_zero = (state == IDLE) && start && !abort && (length == '0);
  assign push        = tag_sr[RD_LAT-1];
  assign pop         = out_valid && out_ready;
  assign drain_done  = (state == DRAIN) && (inflight == '0) && (fifo_count == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && (length != '0)) state_nxt = READ;
        READ:    if (issue && (issued == len_q - LEN_W'(1))) state_nxt = DRAIN;
        DRAIN:   if (drain_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (state != IDLE);
    done      = done_q;
    address_b = issue ? addr : addr_hold;
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    out_last  = out_valid && (pop_idx == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      addr_hold <= '0;
      len_q     <= '0;
      issued    <= '0;
      pop_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= !abort && (drain_done || accept_zero);
      if (accept) begin
        addr    <= base_addr;
        len_q   <= length;
        issued  <= '0;
        pop_idx <= '0;
      end else begin
        if (issue) begin
          addr      <= addr + ADDR_W'(1);
          addr_hold <= addr;
          issued    <= issued + LEN_W'(1);
        end
        if (pop) pop_idx <= pop_idx + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_sr <= '0;
    end else if (abort) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !abort) fifo_mem[wr_ptr] <= read_data_b;
  end

`ifdef PORTB_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        checksum <= '0;
    else if (accept) checksum <= '0;
    else if (pop)    checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_mem_portb_reader.sv
// Directed bench for mem_portb_reader: vector table of transfers plus hand-written corner sequences.
module tb_mem_portb_reader;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] base_addr = '0;
  logic [17:0] length = '0;
  logic [17:0] address_b;
  logic [23:0] read_data_b;
  logic [23:0] out_data;
  logic        busy, done, out_valid, out_last;
`ifdef PORTB_CHECKSUM_EN
  logic [23:0] checksum;
`endif

  logic [23:0] ram [16];
  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    logic [17:0] base;
    logic [17:0] len;
    bit          tog;
    bit          poke;
  } vec_t;

  vec_t vecs [5];

  mem_portb_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .address_b(address_b), .read_data_b(read_data_b), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef PORTB_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data_b <= ram[address_b[3:0]];

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic run_xfer(input vec_t v);
    int got, cyc, first_v, last_pop, done_cyc;
    bit stalled;
    logic [23:0] held;
    logic [17:0] ea;
    logic [3:0] ri;
    @(negedge clk);
    base_addr = v.base; length = v.len; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("busy_after_start", busy, 1);
    got = 0; cyc = 0; first_v = -1; last_pop = -1; done_cyc = -1; stalled = 0; held = '0;
    while (done_cyc < 0 && cyc < 300) begin
      out_ready = v.tog ? ((cyc % 2) == 0) : 1'b1;
      if (v.poke) begin
        if (cyc == 1) begin start = 1'b1; base_addr = 18'h9; length = 18'd2; end
        else start = 1'b0;
      end
      if (!v.tog && cyc < 4 && cyc < int'(v.len)) begin
        ea = v.base + 18'(cyc);
        chk_eq("address_b_seq", address_b, ea);
      end
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        chk_eq("first_valid_latency", cyc, RD_LAT + 1);
      end
      if (stalled) begin
        chk_eq("stall_valid_held", out_valid, 1);
        chk_eq("stall_data_held", out_data, held);
      end
      if (out_valid && out_ready) begin
        ri = 4'(v.base + 18'(got));
        chk_eq("word_data", out_data, ram[ri]);
        chk_eq("word_last", out_last, (got == int'(v.len) - 1));
        got++;
        last_pop = cyc;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        done_cyc = cyc;
        chk_eq("busy_low_at_done", busy, 0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk_eq("word_count", got, v.len);
    chk_eq("done_seen", (done_cyc >= 0), 1);
    chk_eq("done_after_last_pop", (done_cyc - last_pop >= 1) && (done_cyc - last_pop <= 2), 1);
    chk_eq("done_single_pulse", done, 0);
  endtask

  initial begin
    int got, cyc;
    bit saw_valid, saw_done;

    for (int i = 0; i < 16; i++) ram[i] = 24'h100 + 24'(i);
    vecs[0] = '{base: 18'h0,     len: 18'd8, tog: 1'b0, poke: 1'b0};
    vecs[1] = '{base: 18'h0,     len: 18'd8, tog: 1'b1, poke: 1'b0};
    vecs[2] = '{base: 18'h3FFFE, len: 18'd4, tog: 1'b0, poke: 1'b0};
    vecs[3] = '{base: 18'h3,     len: 18'd5, tog: 1'b1, poke: 1'b1};
    vecs[4] = '{base: 18'h7,     len: 18'd1, tog: 1'b0, poke: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_last", out_last, 0);
    chk_eq("rst_out_data", out_data, 0);
    chk_eq("rst_address_b", address_b, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_xfer(vecs[k]);

    // Zero length: done the cycle after start, no words
    @(negedge clk);
    base_addr = 18'h2; length = 18'd0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("len0_done", done, 1);
    chk_eq("len0_busy", busy, 0);
    chk_eq("len0_out_valid", out_valid, 0);
    @(negedge clk);
    chk_eq("len0_done_drop", done, 0);
    chk_eq("len0_out_valid_later", out_valid, 0);

    // Abort after three pops
    @(negedge clk);
    base_addr = 18'h0; length = 18'd8; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0; cyc = 0;
    while (got < 3 && cyc < 50) begin
      if (out_valid && out_ready) got++;
      if (got < 3) begin @(negedge clk); cyc++; end
    end
    chk_eq("abort_reached_3_pops", got, 3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_eq("abort_out_valid", out_valid, 0);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_done", done, 0);
    saw_valid = 0; saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
      if (done) saw_done = 1;
    end
    chk_eq("abort_no_late_words", saw_valid, 0);
    chk_eq("abort_no_done", saw_done, 0);

    // Abort wins over start in the same cycle
    base_addr = 18'h4; length = 18'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_eq("abort_prio_busy", busy, 0);
    saw_valid = 0; saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || busy) saw_valid = 1;
      if (done) saw_done = 1;
    end
    chk_eq("abort_prio_no_activity", saw_valid, 0);
    chk_eq("abort_prio_no_done", saw_done, 0);

    // Asynchronous reset in the middle of READ
    base_addr = 18'h5; length = 18'd8; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_eq("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_done", done, 0);
    chk_eq("midrst_address_b", address_b, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef PORTB_CHECKSUM_EN
    ram[8] = 24'hFFFFFF;
    ram[9] = 24'h000002;
    base_addr = 18'h8; length = 18'd2; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    chk_eq("checksum_done_seen", done, 1);
    chk_eq("checksum_at_done", checksum, 24'h000001);
    @(negedge clk);
    chk_eq("checksum_held", checksum, 24'h000001);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end
endmodule
